// File: rtl/xgmii_rx_decoder.sv
// 64b/66b receive block decoder (Clause 49 subset), 32-bit datapath in, two XGMII words out per block.
// Optional saturating error-block counter on o_err_count when XGMII_DEC_ERR_CNT_EN is defined.
module xgmii_rx_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_data_valid,
  input  logic [HDR_WIDTH-1:0]  i_rx_hdr,
  input  logic                  i_rx_hdr_valid,
  input  logic                  i_block_lock,
  output logic [DATA_WIDTH-1:0] o_xgmii_txd,
  output logic [CTRL_WIDTH-1:0] o_xgmii_txc,
  output logic                  o_xgmii_valid
`ifdef XGMII_DEC_ERR_CNT_EN
  ,
  output logic [15:0]           o_err_count
`endif
);

  logic                    phase;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [HDR_WIDTH-1:0]    hdr_q;
  logic [63:0]             dec_d_q;
  logic [7:0]              dec_c_q;
  logic [1:0]              vld_pipe;

  logic                    cap_hi;
  logic [63:0]             blk, sh;
  logic [63:0]             dec_d;
  logic [7:0]              dec_c;
  logic                    bad, dec_err, term;
  int                      tk;

  // Only a header-less word in second-half phase completes a block.
  assign cap_hi = i_rx_data_valid && !i_rx_hdr_valid && phase;

  always_comb begin
    blk     = {i_rx_data, lo_q};
    sh      = blk >> 8;
    dec_d   = '0;
    dec_c   = '0;
    bad     = 1'b0;
    term    = 1'b1;
    tk      = 0;
    case (blk[7:0])
      8'h87:   tk = 0;
      8'h99:   tk = 1;
      8'hAA:   tk = 2;
      8'hB4:   tk = 3;
      8'hCC:   tk = 4;
      8'hD2:   tk = 5;
      8'hE1:   tk = 6;
      8'hFF:   tk = 7;
      default: term = 1'b0;
    endcase

    if (hdr_q == 2'b01) begin
      dec_d = blk;
      dec_c = 8'h00;
    end else if (hdr_q == 2'b10) begin
      case (blk[7:0])
        8'h1E: begin
          for (int i = 0; i < 8; i++)
            dec_d[8*i +: 8] = (blk[8+7*i +: 7] == 7'd0) ? 8'h07 : 8'hFE;
          dec_c = 8'hFF;
        end
        8'h78: begin
          dec_d = {blk[63:8], 8'hFB};
          dec_c = 8'h01;
        end
        8'h33: begin
          dec_d = {blk[63:40], 8'hFB, 32'h0707_0707};
          dec_c = 8'h1F;
        end
        8'h4B: begin
          dec_d = {32'h0707_0707, blk[31:8], 8'h9C};
          dec_c = 8'hF1;
        end
        default: begin
          if (term) begin
            for (int i = 0; i < 8; i++) begin
              if (i < tk) begin
                dec_d[8*i +: 8] = sh[8*i +: 8];
                dec_c[i]        = 1'b0;
              end else if (i == tk) begin
                dec_d[8*i +: 8] = 8'hFD;
                dec_c[i]        = 1'b1;
              end else begin
                dec_d[8*i +: 8] = 8'h07;
                dec_c[i]        = 1'b1;
              end
            end
          end else begin
            bad = 1'b1;
          end
        end
      endcase
    end else begin
      bad = 1'b1;
    end

    // Loss of lock overrides whatever the block decoded to.
    dec_err = bad || !i_block_lock;
    if (dec_err) begin
      dec_d = {8{8'hFE}};
      dec_c = 8'hFF;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase         <= 1'b0;
      lo_q          <= '0;
      hdr_q         <= '0;
      dec_d_q       <= '0;
      dec_c_q       <= '0;
      vld_pipe      <= '0;
      o_xgmii_txd   <= 32'h0707_0707;
      o_xgmii_txc   <= 4'hF;
      o_xgmii_valid <= 1'b0;
    end else begin
      if (i_rx_data_valid) begin
        if (i_rx_hdr_valid) begin
          lo_q  <= i_rx_data;
          hdr_q <= i_rx_hdr;
          phase <= 1'b1;
        end else if (phase) begin
          phase <= 1'b0;
        end
      end
      vld_pipe <= {vld_pipe[0], cap_hi};
      if (cap_hi) begin
        dec_d_q <= dec_d;
        dec_c_q <= dec_c;
      end
      // Blocks arrive at most every other cycle, so the two stages never collide.
      if (vld_pipe[0]) begin
        o_xgmii_txd   <= dec_d_q[31:0];
        o_xgmii_txc   <= dec_c_q[3:0];
        o_xgmii_valid <= 1'b1;
      end else if (vld_pipe[1]) begin
        o_xgmii_txd   <= dec_d_q[63:32];
        o_xgmii_txc   <= dec_c_q[7:4];
        o_xgmii_valid <= 1'b1;
      end else begin
        o_xgmii_valid <= 1'b0;
      end
    end
  end

`ifdef XGMII_DEC_ERR_CNT_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      o_err_count <= '0;
    else if (cap_hi && dec_err && o_err_count != 16'hFFFF)
      o_err_count <= o_err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_xgmii_rx_decoder.sv
// Directed bench for xgmii_rx_decoder: control/data block decode, errors, stall, resync, reset, back-to-back.
module tb_xgmii_rx_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rx_data;
  logic        rx_dv;
  logic [1:0]  rx_hdr;
  logic        rx_hv;
  logic        lock;
  logic [31:0] txd;
  logic [3:0]  txc;
  logic        vld;
`ifdef XGMII_DEC_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;

  xgmii_rx_decoder dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_rx_data       (rx_data),
    .i_rx_data_valid (rx_dv),
    .i_rx_hdr        (rx_hdr),
    .i_rx_hdr_valid  (rx_hv),
    .i_block_lock    (lock),
    .o_xgmii_txd     (txd),
    .o_xgmii_txc     (txc),
    .o_xgmii_valid   (vld)
`ifdef XGMII_DEC_ERR_CNT_EN
    ,
    .o_err_count     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cur();
    return {27'd0, vld, txc, txd};
  endfunction

  function automatic logic [63:0] w(input logic [3:0] c, input logic [31:0] d);
    return {27'd0, 1'b1, c, d};
  endfunction

  task automatic chk_err(input string tag);
`ifdef XGMII_DEC_ERR_CNT_EN
    chk(tag, {48'd0, err_cnt}, 64'(exp_err));
`else
    chk(tag, {63'd0, vld}, 64'd0);
`endif
  endtask

  // One isolated block: halves on two cycles, then both output words and a quiet cycle.
  task automatic run_blk(input string tag, input logic [1:0] hdr, input logic [31:0] lo,
                         input logic [31:0] hi, input logic lk, input logic is_err,
                         input logic [3:0] c0, input logic [31:0] d0,
                         input logic [3:0] c1, input logic [31:0] d1);
    @(negedge clk); rx_data = lo; rx_dv = 1'b1; rx_hdr = hdr; rx_hv = 1'b1; lock = lk;
    @(negedge clk); rx_data = hi; rx_hv = 1'b0;
    @(negedge clk); rx_dv = 1'b0; lock = 1'b1;
    @(negedge clk); chk({tag, "_lo"}, cur(), w(c0, d0));
    @(negedge clk); chk({tag, "_hi"}, cur(), w(c1, d1));
    @(negedge clk); chk({tag, "_quiet"}, {63'd0, vld}, 64'd0);
    if (is_err) exp_err++;
    chk_err({tag, "_errcnt"});
  endtask

  logic [31:0] blo [16];
  logic [31:0] bhi [16];
  logic [1:0]  bhd [16];
  logic [63:0] elo [16];
  logic [63:0] ehi [16];

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_dv = 1'b0; rx_hdr = '0; rx_hv = 1'b0; lock = 1'b1;
    @(negedge clk);
    chk("rst_state", cur(), {27'd0, 1'b0, 4'hF, 32'h0707_0707});
    chk_err("rst_errcnt");
    @(negedge clk); rst_n = 1'b1;

    run_blk("idle",   2'b10, 32'h0000_001E, 32'h0000_0000, 1, 0, 4'hF, 32'h0707_0707, 4'hF, 32'h0707_0707);
    run_blk("idle_e", 2'b10, 32'h0000_011E, 32'h0000_0000, 1, 0, 4'hF, 32'h0707_07FE, 4'hF, 32'h0707_0707);
    run_blk("start0", 2'b10, 32'h5555_5578, 32'hD555_5555, 1, 0, 4'h1, 32'h5555_55FB, 4'h0, 32'hD555_5555);
    run_blk("start4", 2'b10, 32'h0000_0033, 32'hCCBB_AA99, 1, 0, 4'hF, 32'h0707_0707, 4'h1, 32'hCCBB_AAFB);
    run_blk("ordset", 2'b10, 32'h3322_114B, 32'h1234_5678, 1, 0, 4'h1, 32'h3322_119C, 4'hF, 32'h0707_0707);
    run_blk("data",   2'b01, 32'h0302_0100, 32'h0706_0504, 1, 0, 4'h0, 32'h0302_0100, 4'h0, 32'h0706_0504);
    run_blk("term0",  2'b10, 32'h0000_0087, 32'h0000_0000, 1, 0, 4'hF, 32'h0707_07FD, 4'hF, 32'h0707_0707);
    run_blk("term3",  2'b10, 32'h3322_11B4, 32'h0000_0000, 1, 0, 4'h8, 32'hFD33_2211, 4'hF, 32'h0707_0707);
    run_blk("term7",  2'b10, 32'h3322_11FF, 32'h7766_5544, 1, 0, 4'h0, 32'h4433_2211, 4'h8, 32'hFD77_6655);
    run_blk("hdr00",  2'b00, 32'h0302_0100, 32'h0706_0504, 1, 1, 4'hF, 32'hFEFE_FEFE, 4'hF, 32'hFEFE_FEFE);
    run_blk("hdr11",  2'b11, 32'h0302_0100, 32'h0706_0504, 1, 1, 4'hF, 32'hFEFE_FEFE, 4'hF, 32'hFEFE_FEFE);
    run_blk("badtyp", 2'b10, 32'h0000_0000, 32'h0000_0000, 1, 1, 4'hF, 32'hFEFE_FEFE, 4'hF, 32'hFEFE_FEFE);
    run_blk("nolock", 2'b01, 32'h0302_0100, 32'h0706_0504, 0, 1, 4'hF, 32'hFEFE_FEFE, 4'hF, 32'hFEFE_FEFE);

    // Stall between halves: nothing emitted until the second half shows up.
    @(negedge clk); rx_data = 32'h5555_5578; rx_dv = 1'b1; rx_hdr = 2'b10; rx_hv = 1'b1;
    @(negedge clk); rx_dv = 1'b0; rx_hv = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("stall_quiet", {63'd0, vld}, 64'd0);
    end
    rx_data = 32'hD555_5555; rx_dv = 1'b1;
    @(negedge clk); rx_dv = 1'b0;
    @(negedge clk); chk("stall_lo", cur(), w(4'h1, 32'h5555_55FB));
    @(negedge clk); chk("stall_hi", cur(), w(4'h0, 32'hD555_5555));

    // Resync: a headered word in second-half phase restarts the block.
    @(negedge clk); rx_data = 32'hDEAD_BEEF; rx_dv = 1'b1; rx_hdr = 2'b00; rx_hv = 1'b1;
    @(negedge clk); rx_data = 32'h0000_001E; rx_hdr = 2'b10;
    @(negedge clk); rx_data = 32'h0000_0000; rx_hv = 1'b0;
    @(negedge clk); rx_dv = 1'b0;
    @(negedge clk); chk("resync_lo", cur(), w(4'hF, 32'h0707_0707));
    @(negedge clk); chk("resync_hi", cur(), w(4'hF, 32'h0707_0707));

    // Reset between halves drops the first half; orphan second half is ignored.
    @(negedge clk); rx_data = 32'h5555_5578; rx_dv = 1'b1; rx_hdr = 2'b10; rx_hv = 1'b1;
    @(negedge clk); rx_dv = 1'b0; rx_hv = 1'b0; rst_n = 1'b0; exp_err = 0;
    @(negedge clk); chk("midrst_state", cur(), {27'd0, 1'b0, 4'hF, 32'h0707_0707});
    chk_err("midrst_errcnt");
    rst_n = 1'b1;
    @(negedge clk); rx_data = 32'hD555_5555; rx_dv = 1'b1;
    @(negedge clk); rx_dv = 1'b0;
    repeat (2) begin
      @(negedge clk); chk("orphan_quiet", {63'd0, vld}, 64'd0);
    end
    run_blk("postrst", 2'b01, 32'hA5A5_0F0F, 32'h1122_3344, 1, 0, 4'h0, 32'hA5A5_0F0F, 4'h0, 32'h1122_3344);

    // Reset with a decoded block pending kills both output words.
    @(negedge clk); rx_data = 32'h0302_0100; rx_dv = 1'b1; rx_hdr = 2'b01; rx_hv = 1'b1;
    @(negedge clk); rx_data = 32'h0706_0504; rx_hv = 1'b0;
    @(negedge clk); rx_dv = 1'b0; rst_n = 1'b0;
    @(negedge clk); chk("pendrst_a", {63'd0, vld}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk); chk("pendrst_b", {63'd0, vld}, 64'd0);
    @(negedge clk); chk("pendrst_c", {63'd0, vld}, 64'd0);

    // Back-to-back blocks: random data with every fourth block an idle control block.
    for (int j = 0; j < 16; j++) begin
      if (j % 4 == 3) begin
        bhd[j] = 2'b10; blo[j] = 32'h0000_001E; bhi[j] = 32'h0;
        elo[j] = w(4'hF, 32'h0707_0707); ehi[j] = w(4'hF, 32'h0707_0707);
      end else begin
        bhd[j] = 2'b01; blo[j] = $urandom; bhi[j] = $urandom;
        elo[j] = w(4'h0, blo[j]); ehi[j] = w(4'h0, bhi[j]);
      end
    end
    for (int t = 0; t < 36; t++) begin
      @(negedge clk);
      if (t >= 3 && t % 2 == 1 && (t - 3) / 2 < 16) chk("b2b_lo", cur(), elo[(t-3)/2]);
      if (t >= 4 && t % 2 == 0 && (t - 4) / 2 < 16) chk("b2b_hi", cur(), ehi[(t-4)/2]);
      if (t < 32) begin
        rx_dv = 1'b1;
        if (t % 2 == 0) begin
          rx_data = blo[t/2]; rx_hdr = bhd[t/2]; rx_hv = 1'b1;
        end else begin
          rx_data = bhi[t/2]; rx_hv = 1'b0;
        end
      end else begin
        rx_dv = 1'b0; rx_hv = 1'b0;
      end
    end
    chk("b2b_quiet", {63'd0, vld}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
